// File: rtl/onchip_memory_tester.sv
// rtl/onchip_memory_tester.sv - Avalon-MM write/read-back tester for the on-chip RAM s2 port
module onchip_memory_tester #(
  parameter int MEM_DEPTH = 10240,
  parameter int ADDR_W    = 14,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [14:0]       num_words,
  input  logic [31:0]       seed,
  input  logic              invert,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [31:0]       first_fail_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [14:0]       DEPTH_N   = 15'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [14:0]       len_q, len_d;
  logic [14:0]       idx_q, idx_d;
  logic [31:0]       seed_q, seed_d;
  logic [31:0]       pat_q, pat_d;
  logic              inv_q, inv_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [31:0]       cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
  logic [31:0]       ff_data_q, ff_data_d;

  logic [14:0]       n_clamped;
  logic              last_word;
  logic              aborting;
  logic              mismatch;
  logic [ADDR_W-1:0] addr_inc;
  logic [31:0]       expected;

  assign n_clamped = (num_words > DEPTH_N) ? DEPTH_N : num_words;
  assign last_word = (idx_q == len_q - 15'd1);
  assign aborting  = abort && (state_q != S_IDLE);
  assign mismatch  = cmp_vld_q && (mem_readdata != cmp_exp_q);
  assign addr_inc  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
  assign expected  = pat_q ^ {32{inv_q}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (aborting) begin
      state_d = S_IDLE;
    end else if (!pause) begin
      case (state_q)
        S_IDLE:  if (start) state_d = (n_clamped == '0) ? S_DONE : S_WRITE;
        S_WRITE: if (last_word) state_d = S_READ;
        S_READ:  if (last_word) state_d = S_DRAIN;
        S_DRAIN: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    done           = (state_q == S_DONE);
    mem_chipselect = (state_q == S_WRITE) || (state_q == S_READ);
    mem_write      = (state_q == S_WRITE);
    mem_byteenable = mem_chipselect ? 4'hF : 4'h0;
    mem_address    = mem_chipselect ? addr_q : '0;
    mem_writedata  = mem_write ? expected : '0;
    mem_clken      = ~pause;
  end

  // Datapath: address/pattern walk plus a one-stage compare pipeline matching RAM latency.
  always_comb begin
    base_d     = base_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    seed_d     = seed_q;
    pat_d      = pat_q;
    inv_d      = inv_q;
    cmp_vld_d  = cmp_vld_q;
    cmp_exp_d  = cmp_exp_q;
    cmp_addr_d = cmp_addr_q;
    pass_d     = pass_q;
    err_d      = err_q;
    ff_addr_d  = ff_addr_q;
    ff_data_d  = ff_data_q;
    if (aborting) begin
      cmp_vld_d = 1'b0;
      pass_d    = 1'b0;
    end else if (!pause) begin
      cmp_vld_d  = (state_q == S_READ);
      cmp_exp_d  = expected;
      cmp_addr_d = addr_q;
      if (mismatch) begin
        if (!(&err_q)) err_d = err_q + ERR_W'(1);
        if (err_q == '0) begin
          ff_addr_d = cmp_addr_q;
          ff_data_d = mem_readdata;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_d    = start_addr;
            addr_d    = start_addr;
            len_d     = n_clamped;
            idx_d     = '0;
            seed_d    = seed;
            pat_d     = seed;
            inv_d     = invert;
            err_d     = '0;
            ff_addr_d = '0;
            ff_data_d = '0;
            pass_d    = (n_clamped == '0);
          end
        end
        S_WRITE, S_READ: begin
          if (last_word) begin
            idx_d  = '0;
            addr_d = base_q;
            pat_d  = seed_q;
          end else begin
            idx_d  = idx_q + 15'd1;
            addr_d = addr_inc;
            pat_d  = pat_q + 32'd1;
          end
        end
        S_DRAIN: pass_d = (err_d == '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      seed_q     <= '0;
      pat_q      <= '0;
      inv_q      <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_exp_q  <= '0;
      cmp_addr_q <= '0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ff_addr_q  <= '0;
      ff_data_q  <= '0;
    end else begin
      base_q     <= base_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      seed_q     <= seed_d;
      pat_q      <= pat_d;
      inv_q      <= inv_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_exp_q  <= cmp_exp_d;
      cmp_addr_q <= cmp_addr_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      ff_addr_q  <= ff_addr_d;
      ff_data_q  <= ff_data_d;
    end
  end

  assign pass            = pass_q;
  assign error_count     = err_q;
  assign first_fail_addr = ff_addr_q;
  assign first_fail_data = ff_data_q;

endmodule

// File: tb/tb_onchip_memory_tester.sv
// tb/tb_onchip_memory_tester.sv - self-checking bench for onchip_memory_tester
module tb_onchip_memory_tester;
  localparam int D = 10240;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, pause = 1'b0, invert = 1'b0;
  logic [13:0] start_addr = '0;
  logic [14:0] num_words = '0;
  logic [31:0] seed = '0;
  logic [13:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic        busy, done, pass;
  logic [15:0] error_count;
  logic [13:0] first_fail_addr;
  logic [31:0] first_fail_data;

  onchip_memory_tester dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .pause(pause),
    .start_addr(start_addr), .num_words(num_words), .seed(seed), .invert(invert),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_fail_addr(first_fail_addr),
    .first_fail_data(first_fail_data)
  );

  always #5 clk = ~clk;

  // RAM with 1-cycle read latency; corrupt forces word 5 to read back DEAD.
  logic [31:0] ram [0:D-1];
  logic [31:0] rd_q;
  logic        corrupt = 1'b0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= mem_writedata;
      else rd_q <= (corrupt && mem_address == 14'd5) ? 32'hDEAD : ram[mem_address];
    end
  end
  assign mem_readdata = rd_q;

  int errors = 0;
  int checks = 0;
  int done_k, clk_bad, cs_seen, bad_beats;
  logic r_pass, busy_k1, ab_busy, ab_cs, ab_done, ab_pass, need_tick;
  logic [15:0] r_err;
  logic [13:0] r_ffa;
  logic [31:0] r_ffd;
  logic [13:0] obs_a[$];
  logic        obs_w[$];
  logic [31:0] obs_d[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int sa, input int nw, input logic [31:0] sd, input logic iv,
                     input int pause_k, input int pause_n, input int abort_k);
    if (need_tick) begin @(posedge clk); #1; end
    start_addr = 14'(sa); num_words = 15'(nw); seed = sd; invert = iv; start = 1'b1;
    obs_a.delete(); obs_w.delete(); obs_d.delete();
    done_k = -1; clk_bad = 0; cs_seen = 0; need_tick = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 25000; k++) begin
      pause = (k >= pause_k) && (k < pause_k + pause_n);
      abort = (k == abort_k);
      #1;
      if (k == 1) busy_k1 = busy;
      if (mem_clken !== ~pause) clk_bad++;
      if (mem_chipselect) cs_seen++;
      if (mem_chipselect && !pause) begin
        obs_a.push_back(mem_address); obs_w.push_back(mem_write); obs_d.push_back(mem_writedata);
      end
      if (k == abort_k + 1) begin
        ab_busy = busy; ab_cs = mem_chipselect; ab_done = done; ab_pass = pass;
        need_tick = 1'b0;
        break;
      end
      if (done) begin
        done_k = k; r_pass = pass; r_err = error_count; r_ffa = first_fail_addr; r_ffd = first_fail_data;
        break;
      end
      @(posedge clk); #1;
    end
    pause = 1'b0; abort = 1'b0;
  endtask

  // Reference: word i lives at (sa+i) mod D and holds (sd+i) optionally inverted.
  task automatic verify(input string tag, input int sa, input int nw, input logic [31:0] sd,
                        input logic iv, input int pause_n);
    int n, e_err, e_ffa;
    logic [31:0] pat, e_ffd, seen;
    n = (nw > D) ? D : nw;
    e_err = 0; e_ffa = 0; e_ffd = 0; bad_beats = 0;
    for (int i = 0; i < n; i++) begin
      pat = (sd + 32'(i)) ^ {32{iv}};
      seen = (corrupt && ((sa + i) % D) == 5) ? 32'hDEAD : pat;
      if (seen != pat) begin
        if (e_err == 0) begin e_ffa = (sa + i) % D; e_ffd = seen; end
        e_err++;
      end
      if (obs_a.size() == 2 * n) begin
        if (obs_a[i] != 14'((sa + i) % D) || obs_w[i] !== 1'b1 || obs_d[i] != pat) bad_beats++;
        if (obs_a[n + i] != 14'((sa + i) % D) || obs_w[n + i] !== 1'b0) bad_beats++;
      end
    end
    if (e_err > 65535) e_err = 65535;
    check({tag, " done_cycle"}, 64'(done_k), 64'((n == 0) ? 1 : 2 * n + 2 + pause_n));
    check({tag, " pass"}, 64'(r_pass), 64'(e_err == 0));
    check({tag, " error_count"}, 64'(r_err), 64'(e_err));
    if (e_err != 0) begin
      check({tag, " first_fail_addr"}, 64'(r_ffa), 64'(e_ffa));
      check({tag, " first_fail_data"}, 64'(r_ffd), 64'(e_ffd));
    end
    check({tag, " beat_count"}, 64'(obs_a.size()), 64'(2 * n));
    check({tag, " bad_beats"}, 64'(bad_beats), 64'd0);
    check({tag, " busy_first"}, 64'(busy_k1), 64'(n > 0));
    check({tag, " clken"}, 64'(clk_bad), 64'd0);
  endtask

  initial begin
    int sa, nw;
    logic [31:0] sd;
    logic iv;
    need_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset chipselect", 64'(mem_chipselect), 64'd0);
    check("reset clken", 64'(mem_clken), 64'd1);
    check("reset done_pass", 64'({done, pass}), 64'd0);
    check("reset err", 64'(error_count), 64'd0);
    check("reset ffdata", 64'(first_fail_data), 64'd0);
    reset_n = 1'b1;

    run(0, 4, 32'h1000, 1'b0, -1, 0, -1);
    verify("t1_basic", 0, 4, 32'h1000, 1'b0, 0);
    sd = $urandom;
    iv = 1'($urandom_range(0, 1));
    run(10238, 4, sd, iv, -1, 0, -1);
    verify("t2_wrap", 10238, 4, sd, iv, 0);
    corrupt = 1'b1;
    run(0, 8, 32'h0, 1'b0, -1, 0, -1);
    verify("t3_corrupt", 0, 8, 32'h0, 1'b0, 0);
    corrupt = 1'b0;
    sd = $urandom;
    run(100, 6, sd, 1'b0, 8, 3, -1);
    verify("t4_pause", 100, 6, sd, 1'b0, 3);

    run(200, 8, 32'h55, 1'b0, -1, 0, 3);
    check("t5_abort busy", 64'(ab_busy), 64'd0);
    check("t5_abort cs", 64'(ab_cs), 64'd0);
    check("t5_abort done", 64'(ab_done), 64'd0);
    check("t5_abort pass", 64'(ab_pass), 64'd0);
    sd = $urandom;
    run(300, 5, sd, 1'b1, -1, 0, -1);
    verify("t5_restart", 300, 5, sd, 1'b1, 0);

    run(50, 0, 32'h1, 1'b0, -1, 0, -1);
    verify("t6_zero", 50, 0, 32'h1, 1'b0, 0);
    check("t6_zero no_cs", 64'(cs_seen), 64'd0);

    for (int t = 0; t < 4; t++) begin
      corrupt = 1'($urandom_range(0, 1));
      sa = corrupt ? $urandom_range(0, 5) : $urandom_range(0, D - 1);
      nw = $urandom_range(6, 40);
      sd = $urandom;
      iv = 1'($urandom_range(0, 1));
      run(sa, nw, sd, iv, -1, 0, -1);
      verify($sformatf("rand%0d", t), sa, nw, sd, iv, 0);
    end
    corrupt = 1'b0;

    sd = $urandom;
    run(7, 20000, sd, 1'b0, -1, 0, -1);
    verify("t6_clamp", 7, 20000, sd, 1'b0, 0);

    @(posedge clk); #1;
    start_addr = 14'd0; num_words = 15'd8; seed = 32'h0; invert = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("async_reset busy", 64'(busy), 64'd0);
    check("async_reset cs", 64'(mem_chipselect), 64'd0);
    check("async_reset clken", 64'(mem_clken), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    need_tick = 1'b1;
    run(3, 3, 32'hFFFF_FFFE, 1'b0, -1, 0, -1);
    verify("post_reset", 3, 3, 32'hFFFF_FFFE, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
